// File: rtl/smc_joint_scheduler_if.sv
// Bus between the joint front end, the shared SMC datapath and the scheduler.
// Per-joint buses are packed [joint][bit], so joint j occupies bits [32j+31:32j].
interface smc_joint_scheduler_if #(
    parameter int NUM_JOINTS = 4
);
    logic                         start;
    logic [NUM_JOINTS-1:0]        joint_mask;
    logic [NUM_JOINTS-1:0][31:0]  thetad_bus;
    logic [NUM_JOINTS-1:0][31:0]  dthetad_bus;
    logic [NUM_JOINTS-1:0][31:0]  ddthetad_bus;
    logic [NUM_JOINTS-1:0][31:0]  thetan_bus;
    logic [NUM_JOINTS-1:0][31:0]  dthetan_bus;
    logic [31:0]                  smc_thetad;
    logic [31:0]                  smc_dthetad;
    logic [31:0]                  smc_ddthetad;
    logic [31:0]                  smc_thetan;
    logic [31:0]                  smc_dthetan;
    logic [31:0]                  smc_u;
    logic [NUM_JOINTS-1:0][31:0]  u_bus;
    logic [NUM_JOINTS-1:0]        u_valid;
    logic                         busy;
    logic                         done;
    logic                         overrun;

    modport slave (
        input  start, joint_mask, thetad_bus, dthetad_bus, ddthetad_bus,
               thetan_bus, dthetan_bus, smc_u,
        output smc_thetad, smc_dthetad, smc_ddthetad, smc_thetan, smc_dthetan,
               u_bus, u_valid, busy, done, overrun
    );

    modport master (
        output start, joint_mask, thetad_bus, dthetad_bus, ddthetad_bus,
               thetan_bus, dthetan_bus, smc_u,
        input  smc_thetad, smc_dthetad, smc_ddthetad, smc_thetan, smc_dthetan,
               u_bus, u_valid, busy, done, overrun
    );
endinterface

// File: rtl/smc_joint_scheduler.sv
// Sweeps the enabled joints through one shared SMC datapath, one joint at a time.
// Optional macro SMC_SAT_EN clamps captured torque to [-U_LIMIT, +U_LIMIT].
module smc_joint_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        cap,
    input  logic [31:0] d,
    output logic [31:0] q,
    output logic        vld
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else begin
            if (clr) vld <= 1'b0;
            if (cap) begin
                q   <= d;
                vld <= 1'b1;
            end
        end
    end
endmodule

module smc_joint_scheduler #(
    parameter int          NUM_JOINTS    = 4,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] U_LIMIT       = 32'd30000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    smc_joint_scheduler_if.slave  bus
);
    localparam int JW = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef SMC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    typedef struct packed {
        logic [31:0] thetad;
        logic [31:0] dthetad;
        logic [31:0] ddthetad;
        logic [31:0] thetan;
        logic [31:0] dthetan;
    } ops_t;

    logic [2:0]                  state;
    logic [NUM_JOINTS-1:0]       mask_q;
    logic [JW-1:0]               jsel;
    logic [CW-1:0]               cnt;
    ops_t                        ops_q;
    logic                        busy_q, done_q, overrun_q;
    logic                        accept;
    logic [JW:0]                 first_hit, next_hit;
    logic [31:0]                 cap_val;
    logic [NUM_JOINTS-1:0][31:0] u_q;
    logic [NUM_JOINTS-1:0]       v_q;

    // {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [JW:0] find_from(input logic [NUM_JOINTS-1:0] m, input int from);
        logic [JW:0] r;
        r = '0;
        for (int i = NUM_JOINTS - 1; i >= 0; i--)
            if (i >= from && m[i]) r = {1'b1, JW'(i)};
        return r;
    endfunction

    function automatic logic [31:0] clamp_u(input logic [31:0] u);
        if (!SAT_EN) return u;
        if ($signed(u) > $signed(U_LIMIT)) return U_LIMIT;
        if ($signed(u) < -$signed(U_LIMIT)) return -U_LIMIT;
        return u;
    endfunction

    // Scheduling is only open in IDLE, which is exactly when busy is low.
    assign accept    = (state == IDLE) && bus.start;
    assign first_hit = find_from(bus.joint_mask, 0);
    assign next_hit  = find_from(mask_q, int'(jsel) + 1);
    assign cap_val   = clamp_u(bus.smc_u);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask_q    <= '0;
            jsel      <= '0;
            cnt       <= '0;
            ops_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start && busy_q) overrun_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask_q    <= bus.joint_mask;
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (first_hit[JW]) begin
                            jsel  <= first_hit[JW-1:0];
                            state <= LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    ops_q.thetad   <= bus.thetad_bus[jsel];
                    ops_q.dthetad  <= bus.dthetad_bus[jsel];
                    ops_q.ddthetad <= bus.ddthetad_bus[jsel];
                    ops_q.thetan   <= bus.thetan_bus[jsel];
                    ops_q.dthetan  <= bus.dthetan_bus[jsel];
                    cnt            <= '0;
                    state          <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) state <= CAPTURE;
                    else                 cnt   <= cnt + 1'b1;
                end
                CAPTURE: begin
                    if (next_hit[JW]) begin
                        jsel  <= next_hit[JW-1:0];
                        state <= LOAD;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < NUM_JOINTS; j++) begin : g_slot
        smc_joint_slot u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (accept),
            .cap   ((state == CAPTURE) && (jsel == JW'(j))),
            .d     (cap_val),
            .q     (u_q[j]),
            .vld   (v_q[j])
        );
    end

    assign bus.u_bus        = u_q;
    assign bus.u_valid      = v_q;
    assign bus.smc_thetad   = ops_q.thetad;
    assign bus.smc_dthetad  = ops_q.dthetad;
    assign bus.smc_ddthetad = ops_q.ddthetad;
    assign bus.smc_thetan   = ops_q.thetan;
    assign bus.smc_dthetan  = ops_q.dthetan;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_smc_joint_scheduler.sv
// Randomized bench for smc_joint_scheduler against a sweep-level reference model.
module tb_smc_joint_scheduler;
    localparam int N = 4;
    localparam int S = 2;
    localparam int ULIM = 1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    smc_joint_scheduler_if #(.NUM_JOINTS(N)) ifc();

    smc_joint_scheduler #(.NUM_JOINTS(N), .SETTLE_CYCLES(S), .U_LIMIT(32'd1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int total = 0;
    int bad   = 0;

    logic        ovr_en;
    logic [31:0] ovr_val;
    logic [31:0] op [N][5];
    logic [31:0] exp_u [N];
    logic [N-1:0] exp_v;
    logic [31:0] exp_smc [5];

    // Stand-in for the shared SMC: any function touching all five operands.
    function automatic logic [31:0] smc_f(input logic [31:0] a, b, c, d, e);
        logic [31:0] h;
        h = {e[31], e[31:1]};
        return a + 32'd1 + (b ^ c) - d + h;
    endfunction

    assign ifc.smc_u = ovr_en ? ovr_val :
        smc_f(ifc.smc_thetad, ifc.smc_dthetad, ifc.smc_ddthetad, ifc.smc_thetan, ifc.smc_dthetan);

    function automatic logic [31:0] exp_cap(input logic [31:0] u);
`ifdef SMC_SAT_EN
        if ($signed(u) > ULIM) return ULIM;
        if ($signed(u) < -ULIM) return -ULIM;
`endif
        return u;
    endfunction

    function automatic int exp_lat(input logic [N-1:0] m);
        return $countones(m) * (S + 2) + 1;
    endfunction

    task automatic set_ops();
        for (int j = 0; j < N; j++) begin
            ifc.thetad_bus[j]   = op[j][0];
            ifc.dthetad_bus[j]  = op[j][1];
            ifc.ddthetad_bus[j] = op[j][2];
            ifc.thetan_bus[j]   = op[j][3];
            ifc.dthetan_bus[j]  = op[j][4];
        end
    endtask

    task automatic rand_ops();
        for (int j = 0; j < N; j++)
            for (int k = 0; k < 5; k++) op[j][k] = $urandom;
        set_ops();
    endtask

    task automatic model_sweep(input logic [N-1:0] m);
        exp_v = m;
        for (int j = 0; j < N; j++)
            if (m[j]) begin
                exp_u[j] = exp_cap(smc_f(op[j][0], op[j][1], op[j][2], op[j][3], op[j][4]));
                for (int k = 0; k < 5; k++) exp_smc[k] = op[j][k];
            end
    endtask

    task automatic model_reset();
        exp_v = '0;
        for (int j = 0; j < N; j++) exp_u[j] = '0;
        for (int k = 0; k < 5; k++) exp_smc[k] = '0;
    endtask

    // Issues one start, scrambles the mask after acceptance, optionally pokes start
    // again after cycle poke, and returns cycles from start edge to done (-1 on timeout).
    task automatic do_sweep(input logic [N-1:0] m, input int poke, output int lat);
        @(negedge clk);
        ifc.joint_mask = m;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.joint_mask = N'($urandom);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            if (ifc.done) begin
                lat = c;
                break;
            end
            if (c == poke) ifc.start = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.start = 1'b0;
        ifc.joint_mask = '0;
        ovr_en = 1'b0;
        ovr_val = '0;
        rand_ops();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if ({ifc.busy, ifc.done, ifc.overrun} !== 3'b000) begin bad++;
            $display("FAIL reset_flags: got %b want 000", {ifc.busy, ifc.done, ifc.overrun}); end
        total++; if (ifc.u_valid !== '0) begin bad++;
            $display("FAIL reset_u_valid: got %h want 0", ifc.u_valid); end
        total++; if (ifc.u_bus !== '0) begin bad++;
            $display("FAIL reset_u_bus: got %h want 0", ifc.u_bus); end
        total++; if ({ifc.smc_thetad, ifc.smc_dthetad, ifc.smc_ddthetad, ifc.smc_thetan, ifc.smc_dthetan} !== 160'd0) begin bad++;
            $display("FAIL reset_smc: got %h want 0", {ifc.smc_thetad, ifc.smc_dthetad, ifc.smc_ddthetad, ifc.smc_thetan, ifc.smc_dthetan}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full();
        int lat;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < 5; k++) op[j][k] = '0;
            op[j][0] = 32'(10 * j);
        end
        set_ops();
        do_sweep(4'hF, 0, lat);
        model_sweep(4'hF);
        total++; if (lat != 17) begin bad++; $display("FAIL full_latency: got %0d want 17", lat); end
        total++; if (ifc.u_bus !== {32'd31, 32'd21, 32'd11, 32'd1}) begin bad++;
            $display("FAIL full_u_bus: got %h want 31,21,11,1", ifc.u_bus); end
        total++; if (ifc.u_valid !== 4'hF) begin bad++; $display("FAIL full_u_valid: got %h want f", ifc.u_valid); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL full_busy_end: got %b want 0", ifc.busy); end
        @(posedge clk);
        #1;
        total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL full_done_pulse: got %b want 0", ifc.done); end
    endtask

    task automatic test_sparse();
        int lat;
        rand_ops();
        do_sweep(4'b1010, 0, lat);
        model_sweep(4'b1010);
        total++; if (lat != 9) begin bad++; $display("FAIL sparse_latency: got %0d want 9", lat); end
        total++; if (ifc.u_valid !== 4'b1010) begin bad++; $display("FAIL sparse_u_valid: got %b want 1010", ifc.u_valid); end
        for (int j = 0; j < N; j++) begin
            total++; if (ifc.u_bus[j] !== exp_u[j]) begin bad++;
                $display("FAIL sparse_slot%0d: got %h want %h", j, ifc.u_bus[j], exp_u[j]); end
        end
        total++; if (ifc.smc_thetad !== op[3][0] || ifc.smc_dthetan !== op[3][4]) begin bad++;
            $display("FAIL sparse_smc_last: got %h/%h want %h/%h", ifc.smc_thetad, ifc.smc_dthetan, op[3][0], op[3][4]); end
    endtask

    task automatic test_zero_mask();
        int lat;
        rand_ops();
        do_sweep('0, 0, lat);
        model_sweep('0);
        total++; if (lat != 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", lat); end
        total++; if (ifc.u_valid !== '0) begin bad++; $display("FAIL zero_u_valid: got %h want 0", ifc.u_valid); end
        total++; if ({ifc.smc_thetad, ifc.smc_dthetad, ifc.smc_ddthetad, ifc.smc_thetan, ifc.smc_dthetan}
                     !== {exp_smc[0], exp_smc[1], exp_smc[2], exp_smc[3], exp_smc[4]}) begin bad++;
            $display("FAIL zero_smc_hold: got %h want %h", ifc.smc_thetad, exp_smc[0]); end
        for (int j = 0; j < N; j++) begin
            total++; if (ifc.u_bus[j] !== exp_u[j]) begin bad++;
                $display("FAIL zero_slot%0d: got %h want %h", j, ifc.u_bus[j], exp_u[j]); end
        end
    endtask

    task automatic test_overrun();
        int lat;
        rand_ops();
        do_sweep(4'hF, 5, lat);
        model_sweep(4'hF);
        total++; if (lat != 17) begin bad++; $display("FAIL ovr_latency: got %0d want 17", lat); end
        total++; if (ifc.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", ifc.overrun); end
        total++; if (ifc.u_bus[2] !== exp_u[2]) begin bad++;
            $display("FAIL ovr_result: got %h want %h", ifc.u_bus[2], exp_u[2]); end
        do_sweep(4'b0001, 0, lat);
        model_sweep(4'b0001);
        total++; if (ifc.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", ifc.overrun); end
        total++; if (lat != exp_lat(4'b0001)) begin bad++; $display("FAIL ovr_next_latency: got %0d want %0d", lat, exp_lat(4'b0001)); end
        // Poke lands in the DONE cycle of a one-joint sweep.
        do_sweep(4'b0001, exp_lat(4'b0001) - 1, lat);
        model_sweep(4'b0001);
        total++; if (ifc.overrun !== 1'b1) begin bad++; $display("FAIL ovr_done_cycle: got %b want 1", ifc.overrun); end
    endtask

    task automatic test_sat();
        int lat;
        logic [31:0] in_v [3];
        logic [31:0] want [3];
        in_v[0] = 32'd5000; in_v[1] = -32'd5000; in_v[2] = 32'd999;
`ifdef SMC_SAT_EN
        want[0] = 32'd1000; want[1] = -32'd1000; want[2] = 32'd999;
`else
        want[0] = 32'd5000; want[1] = -32'd5000; want[2] = 32'd999;
`endif
        ovr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ovr_val = in_v[i];
            do_sweep(4'b0001, 0, lat);
            model_sweep(4'b0001);
            exp_u[0] = want[i];
            total++; if (ifc.u_bus[0] !== want[i]) begin bad++;
                $display("FAIL sat_%0d: got %0d want %0d", i, $signed(ifc.u_bus[0]), $signed(want[i])); end
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        logic [N-1:0] m;
        for (int it = 0; it < 25; it++) begin
            rand_ops();
            m = N'($urandom);
            do_sweep(m, 0, lat);
            model_sweep(m);
            total++; if (lat != exp_lat(m)) begin bad++;
                $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, exp_lat(m)); end
            total++; if (ifc.u_valid !== exp_v) begin bad++;
                $display("FAIL rand%0d_u_valid: got %b want %b", it, ifc.u_valid, exp_v); end
            for (int j = 0; j < N; j++) begin
                total++; if (ifc.u_bus[j] !== exp_u[j]) begin bad++;
                    $display("FAIL rand%0d_slot%0d: got %h want %h", it, j, ifc.u_bus[j], exp_u[j]); end
            end
            total++; if ({ifc.smc_thetad, ifc.smc_dthetad, ifc.smc_ddthetad, ifc.smc_thetan, ifc.smc_dthetan}
                         !== {exp_smc[0], exp_smc[1], exp_smc[2], exp_smc[3], exp_smc[4]}) begin bad++;
                $display("FAIL rand%0d_smc: got %h want %h", it, ifc.smc_thetad, exp_smc[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        rand_ops();
        @(negedge clk);
        ifc.joint_mask = 4'hF;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        // Joint 2 is in its settle window after the tenth edge.
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if ({ifc.busy, ifc.done, ifc.overrun} !== 3'b000) begin bad++;
            $display("FAIL mid_rst_flags: got %b want 000", {ifc.busy, ifc.done, ifc.overrun}); end
        total++; if (ifc.u_bus !== '0 || ifc.u_valid !== '0) begin bad++;
            $display("FAIL mid_rst_u: got %h/%h want 0/0", ifc.u_bus, ifc.u_valid); end
        total++; if (ifc.smc_thetad !== '0 || ifc.smc_dthetan !== '0) begin bad++;
            $display("FAIL mid_rst_smc: got %h/%h want 0/0", ifc.smc_thetad, ifc.smc_dthetan); end
        @(negedge clk);
        rst_n = 1'b1;
        do_sweep(4'hF, 0, lat);
        model_sweep(4'hF);
        total++; if (lat != 17) begin bad++; $display("FAIL mid_rst_latency: got %0d want 17", lat); end
        for (int j = 0; j < N; j++) begin
            total++; if (ifc.u_bus[j] !== exp_u[j]) begin bad++;
                $display("FAIL mid_rst_slot%0d: got %h want %h", j, ifc.u_bus[j], exp_u[j]); end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_sparse();
        test_zero_mask();
        test_overrun();
        test_sat();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
